// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: assembles opcode/addr/data/checksum frames into command or error strobes
module cmd_frame_parser #(
    parameter int         TIMEOUT = 16,
    parameter logic [7:0] OP_MAX  = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  cmd_op,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        cmd_vld,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA_H, DATA_L, CHK} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    state_t     state, state_nx;
    logic [7:0] op_q, addr_q, dh_q, dl_q, acc, tcnt;
    logic       op_ok, tmo;
    assign busy = state != IDLE;
    // next-state: advance one field per accepted byte, fall back to IDLE on timeout
    always_comb begin
        op_ok    = din != 8'd0 && din <= OP_MAX;
        tmo      = busy && !din_vld && tcnt == TMO_LAST;
        state_nx = state;
        if (din_vld) begin
            case (state)
                IDLE:    state_nx = op_ok ? ADDR : IDLE;
                ADDR:    state_nx = DATA_H;
                DATA_H:  state_nx = DATA_L;
                DATA_L:  state_nx = CHK;
                default: state_nx = IDLE;
            endcase
        end else if (tmo) begin
            state_nx = IDLE;
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nx;
    end
    // inter-byte gap counter, cleared by any byte and whenever the FSM rests in IDLE
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) tcnt <= '0;
        else       tcnt <= (din_vld || state_nx == IDLE) ? '0 : tcnt + 8'd1;
    end
    // field capture, running checksum and registered result strobes
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            dh_q     <= '0;
            dl_q     <= '0;
            acc      <= '0;
            cmd_op   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            cmd_vld  <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            cmd_vld <= 1'b0;
            err     <= 1'b0;
            if (din_vld) begin
                case (state)
                    IDLE: begin
                        if (op_ok) begin
                            op_q <= din;
                            acc  <= din;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end
                    end
                    ADDR: begin
                        addr_q <= din;
                        acc    <= acc + din;
                    end
                    DATA_H: begin
                        dh_q <= din;
                        acc  <= acc + din;
                    end
                    DATA_L: begin
                        dl_q <= din;
                        acc  <= acc + din;
                    end
                    default: begin
                        if (din == acc) begin
                            cmd_vld  <= 1'b1;
                            cmd_op   <= op_q;
                            cmd_addr <= addr_q;
                            cmd_data <= {dh_q, dl_q};
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                    end
                endcase
            end else if (tmo) begin
                err      <= 1'b1;
                err_code <= 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed frames with a queue scoreboard checked by a strobe monitor
module tb_cmd_frame_parser;
    logic        clk = 1'b0, rst_n = 1'b1, din_vld = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  cmd_op, cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_vld, err, busy;
    logic [1:0]  err_code;
    int compared = 0, mismatched = 0, cyc = 0;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [7:0]  op, addr;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [7:0]  m_op = 8'h00, m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;

    cmd_frame_parser #(.TIMEOUT(16), .OP_MAX(8'h03)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_vld(cmd_vld), .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic exp_busy);
        @(negedge clk);
        chk("busy", 32'(busy), 32'(exp_busy));
        din = b;
        din_vld = 1'b1;
    endtask

    task automatic gap(input int n, input logic exp_busy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_gap", 32'(busy), 32'(exp_busy));
            din_vld = 1'b0;
        end
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data, input int dly);
        m_op = op;
        m_addr = addr;
        m_data = data;
        q.push_back('{1'b0, 2'd0, op, addr, data, cyc + dly});
    endtask

    task automatic push_err(input logic [1:0] code, input int dly);
        q.push_back('{1'b1, code, m_op, m_addr, m_data, cyc + dly});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_op"}, 32'(cmd_op), 0);
        chk({nm, "_addr"}, 32'(cmd_addr), 0);
        chk({nm, "_data"}, 32'(cmd_data), 0);
        chk({nm, "_vld"}, 32'(cmd_vld), 0);
        chk({nm, "_err"}, 32'(err), 0);
        chk({nm, "_code"}, 32'(err_code), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    // monitor: every strobe must match the head of the queue in content and cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            if (cmd_vld || err) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_strobe cyc=%0d: got cmd_vld=%b err=%b code=%0d, want no strobe", cyc, cmd_vld, err, err_code);
                end else begin
                    e = q.pop_front();
                    if (!((cmd_vld == !e.is_err) && (err == e.is_err) && cmd_op == e.op && cmd_addr == e.addr &&
                          cmd_data == e.data && (!e.is_err || err_code == e.code) && e.due == cyc)) begin
                        mismatched++;
                        $display("FAIL strobe cyc=%0d: got vld=%b err=%b code=%0d op=%h addr=%h data=%h, want err=%b code=%0d op=%h addr=%h data=%h at cyc=%0d",
                                 cyc, cmd_vld, err, err_code, cmd_op, cmd_addr, cmd_data,
                                 e.is_err, e.code, e.op, e.addr, e.data, e.due);
                    end
                end
            end else if (q.size() != 0 && q[0].due < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missing_strobe cyc=%0d: got no strobe, want err=%b code=%0d at cyc=%0d", cyc, q[0].is_err, q[0].code, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        send(8'h01, 0); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1); send(8'h57, 1);
        push_cmd(8'h01, 8'h10, 16'h1234, 1);
        gap(2, 0);

        send(8'h01, 0); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1); send(8'h58, 1);
        push_err(2'd1, 1);
        gap(2, 0);
        send(8'h02, 0); send(8'h20, 1); send(8'h00, 1); send(8'h05, 1); send(8'h27, 1);
        push_cmd(8'h02, 8'h20, 16'h0005, 1);
        gap(2, 0);

        send(8'h00, 0); push_err(2'd3, 1);
        gap(1, 0);
        send(8'h04, 0); push_err(2'd3, 1);
        gap(1, 0);
        send(8'h03, 0); send(8'h01, 1); send(8'h00, 1); send(8'h00, 1); send(8'h04, 1);
        push_cmd(8'h03, 8'h01, 16'h0000, 1);
        gap(2, 0);

        send(8'h01, 0); send(8'h10, 1);
        push_err(2'd2, 17);
        gap(16, 1);
        gap(2, 0);
        send(8'h01, 0); send(8'h10, 1);
        gap(15, 1);
        send(8'h12, 1); send(8'h34, 1); send(8'h57, 1);
        push_cmd(8'h01, 8'h10, 16'h1234, 1);
        gap(2, 0);

        send(8'h01, 0); gap(1, 1); send(8'h10, 1); gap(1, 1); send(8'h12, 1); gap(1, 1);
        send(8'h34, 1); gap(1, 1); send(8'h57, 1);
        push_cmd(8'h01, 8'h10, 16'h1234, 1);
        send(8'h02, 0); send(8'h20, 1); send(8'h00, 1); send(8'h05, 1); send(8'h27, 1);
        push_cmd(8'h02, 8'h20, 16'h0005, 1);
        gap(2, 0);

        send(8'h01, 0); send(8'h10, 1); send(8'h12, 1);
        @(negedge clk);
        rst_n = 1'b1;
        din_vld = 1'b0;
        #1;
        chk_zero("mid_reset");
        m_op = 8'h00; m_addr = 8'h00; m_data = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        send(8'h01, 0); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1); send(8'h57, 1);
        push_cmd(8'h01, 8'h10, 16'h1234, 1);
        gap(3, 0);

        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Downstream consumer of the opcode detector's byte stream (dout/dout_vld) in the temperature-monitor receive path.
- Assembles each post-preamble frame of opcode, address, data high, data low and checksum into one command word. Validates opcode and checksum.
- Issues a single-cycle command strobe to the register/threshold logic, or an error strobe with a reason code.
- Aborts partial frames on an inter-byte timeout.

Parameters:
- TIMEOUT, 16: consecutive cycles without din_vld, inside a frame, that abort the frame (legal range 2..255).
- OP_MAX, 8'h03: highest legal opcode. Legal opcodes are 8'h01..OP_MAX.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1). Port name is fixed.
- din  input  8  byte from the opcode detector.
- din_vld  input  1  din valid; one byte per asserted cycle; may assert on consecutive cycles.
- cmd_op  output  8  opcode of the last good frame.
- cmd_addr  output  8  address of the last good frame.
- cmd_data  output  16  data of the last good frame, {data_h, data_l}.
- cmd_vld  output  1  one-cycle strobe: cmd_* fields updated and valid.
- err  output  1  one-cycle strobe: frame rejected.
- err_code  output  2  1 = checksum mismatch, 2 = timeout, 3 = illegal opcode; 0 when idle. Held until the next err.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, checksum accumulator 0. Reset assertion mid-frame discards the frame immediately, with no strobe.
- Per-byte FSM; transitions only on cycles with din_vld=1 unless a timeout fires:
  - IDLE: byte = opcode.
    - If 1 <= byte <= OP_MAX: latch opcode, acc = byte, go to ADDR.
    - Otherwise: err=1, err_code=3 next cycle, stay in IDLE.
  - ADDR: latch address, acc += byte, go to DATA_H.
  - DATA_H: latch data high, acc += byte, go to DATA_L.
  - DATA_L: latch data low, acc += byte, go to CHK.
  - CHK:
    - If byte == acc: next cycle cmd_vld=1 and cmd_op/cmd_addr/cmd_data load the latched fields.
    - Otherwise: err=1, err_code=1, and cmd_* stay unchanged.
    - Either way, go to IDLE.
- Checksum arithmetic: 8-bit sum modulo 256, with carries discarded.
- Latency: the strobe (cmd_vld or err) comes 1 cycle after the accepting clock edge of the last byte. cmd_* fields hold between strobes.
- Back-to-back frames: a new opcode may arrive the cycle immediately after the CHK byte. The FSM is already in IDLE then, so no bytes are dropped. cmd_vld of frame N may coincide with the acceptance of frame N+1's opcode.
- Timeout:
  - Counter runs only outside IDLE.
  - Clears on every din_vld and on entry to IDLE.
  - Increments on each non-IDLE cycle with din_vld=0.
  - When the counter == TIMEOUT-1 and din_vld=0: go to IDLE, err=1, err_code=2 next cycle.
  - If din_vld=1 arrives on that same cycle, the byte is accepted and no timeout occurs.
- Never both cmd_vld and err in the same cycle.
- busy: combinational from the state register (state != IDLE).
- No backpressure: every byte presented with din_vld is consumed.

Test Plan:
- Good frame: bytes 01,10,12,34,57 on consecutive cycles, after reset release -> one cycle after byte 57: cmd_vld=1, cmd_op=01, cmd_addr=10, cmd_data=1234, err=0. busy high for 4 cycles.
- Bad checksum: 01,10,12,34,58 -> err=1, err_code=1, cmd_vld=0, cmd_* still hold the previous good values. Then 02,20,00,05,27 -> cmd_vld=1, cmd_data=0005.
- Illegal opcode: single bytes 00, then 04 (OP_MAX=03) -> two err pulses with err_code=3, busy never asserts. Then 03,01,00,00,04 -> cmd_vld=1.
- Timeout (TIMEOUT=16): send 01,10 then idle -> err=1, err_code=2 on the cycle after the 16th idle cycle, busy falls. Repeat with the 3rd byte arriving on idle cycle 16 -> no err; frame continues.
- Gapped and back-to-back:
  - Frame 01,10,12,34,57 with din_vld toggling 1/0 -> same result as the good frame.
  - Immediately follow with 02,20,00,05,27 with no gap -> two cmd_vld pulses 5 cycles apart.
- Reset mid-frame: assert rst_n (high) after 01,10,12 -> all outputs 0, no strobe. After release, 01,10,12,34,57 -> cmd_vld=1 with correct fields.
